// File: rtl/comm_link_pkg.sv
// Shared types and defaults for the comm-link transmit path.
package comm_link_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam int unsigned DEFAULT_CH_WIDTH      = 8;
  localparam int unsigned DEFAULT_LG_DECIMATION = 3;
  localparam int unsigned DEFAULT_CREDITS       = 32;
  localparam int unsigned EVT_CNT_W             = 7;

  // Bits needed to hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sso_token_sync.sv
// Synchronizes the far-side token line and emits a registered one-cycle pulse per edge.
module sso_token_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic token_i,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      event_o <= 1'b0;
    end else begin
      sync_q[0] <= token_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q  <= sync_q[SYNC_STAGES-1];
      event_o <= sync_q[SYNC_STAGES-1] != hist_q;
    end
  end

endmodule

// File: rtl/sso_credit_serializer.sv
// Credit-gated serializer: splits each input word into beats over byte-wide
// source-synchronous channels; credits come back as token-line edges.
module sso_credit_serializer
  import comm_link_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned CH_WIDTH      = DEFAULT_CH_WIDTH,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned CREDITS       = DEFAULT_CREDITS,
  parameter int unsigned LG_DECIMATION = DEFAULT_LG_DECIMATION,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WORD_WIDTH-1:0]                 data_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  input  logic                                  token_i,
  output logic                                  io_valid_o,
  output logic [CHANNELS*CH_WIDTH-1:0]          io_data_o,
  output logic [cnt_width(CREDITS)-1:0]         credit_cnt_o,
  output logic [EVT_CNT_W-1:0]                  sent_cnt_o,
  output logic [EVT_CNT_W-1:0]                  token_cnt_o,
  output logic                                  overflow_o
);

  localparam int unsigned IO_W   = CHANNELS * CH_WIDTH;
  localparam int unsigned BEATS  = WORD_WIDTH / IO_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW     = cnt_width(CREDITS);
  localparam int unsigned SUM_W  = CW + LG_DECIMATION + 1;
  localparam int unsigned INC    = 2 ** LG_DECIMATION;

  if (WORD_WIDTH != CHANNELS * CH_WIDTH * BEATS || BEATS == 0) begin : g_bad_width
    $error("WORD_WIDTH must equal CHANNELS*CH_WIDTH*BEATS");
  end

  state_t              state, state_next;
  logic [BEAT_W-1:0]   beat_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic                last_beat;
  logic                accept;
  logic                tok_evt;
  logic [SUM_W-1:0]    credit_sum;

  sso_token_sync #(.SYNC_STAGES(SYNC_STAGES)) u_token_sync (
    .clk     (clk),
    .rst     (rst),
    .token_i (token_i),
    .event_o (tok_evt)
  );

  assign last_beat = beat_q == BEAT_W'(BEATS - 1);
  assign accept    = valid_i && ready_o;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (last_beat && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    io_valid_o = 1'b0;
    ready_o    = 1'b0;
    if (state == SEND) io_valid_o = 1'b1;
    if ((state == IDLE || last_beat) && credit_cnt_o != '0) ready_o = 1'b1;
  end

  // Net credit change for this cycle; an accept and a token may coincide
  always_comb begin
    credit_sum = SUM_W'(credit_cnt_o);
    if (tok_evt) credit_sum = credit_sum + SUM_W'(INC);
    if (accept)  credit_sum = credit_sum - SUM_W'(1);
  end

  // Word register, beat mux and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q       <= '0;
      beat_q       <= '0;
      io_data_o    <= '0;
      credit_cnt_o <= CW'(CREDITS);
      sent_cnt_o   <= '0;
      token_cnt_o  <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (accept) begin
        word_q    <= data_i;
        beat_q    <= '0;
        io_data_o <= data_i[IO_W-1:0];
      end else if (state == SEND && !last_beat) begin
        beat_q    <= beat_q + BEAT_W'(1);
        io_data_o <= word_q[(int'(beat_q) + 1) * int'(IO_W) +: IO_W];
      end
      if (accept)  sent_cnt_o  <= sent_cnt_o + EVT_CNT_W'(1);
      if (tok_evt) token_cnt_o <= token_cnt_o + EVT_CNT_W'(1);
      if (accept || tok_evt) begin
        if (credit_sum > SUM_W'(CREDITS)) begin
          credit_cnt_o <= CW'(CREDITS);
          overflow_o   <= 1'b1;
        end else begin
          credit_cnt_o <= credit_sum[CW-1:0];
        end
      end
    end
  end

endmodule
